id_ex_dump_tx: RTL and testbench
================================

# id_ex_dump_tx

Debug-side reader of the ID/EX pipeline latch. On a dump request it snapshots every ID/EX output field in one cycle and serializes them as a fixed 26-byte frame over a byte-wide valid/ready stream. The stream feeds the debug UART transmitter. The block sits beside the ID/EX register, takes its `o_*` outputs as inputs, and never stalls or alters the pipeline.

## Interface
- NBITS, 32: datapath width; the frame layout requires 32.
- HEADER, 8'hA5: first byte of every frame.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_dump_req  in  1  start a dump; sampled only when idle.
- i_pc, i_ALU_src_A, i_ALU_src_B, i_AGU_src_addr  in  NBITS each  ID/EX datapath words.
- i_rd, i_rt, i_rs  in  5 each  register indices.
- i_addr_offset  in  26  immediate or jump field.
- i_ALU_opcode  in  4  ALU opcode.
- i_AGU_opcode  in  3  AGU opcode.
- i_ALU_dst, i_flg_mem_size, i_flg_ALU_src_A  in  2 each  control fields.
- i_flg_equal, i_flg_unsign, i_AGU_dst, i_flg_branch, i_flg_jump, i_flg_reg_wr_en, i_flg_mem_wr_en, i_flg_wb_src, i_flg_ALU_src_B  in  1 each  control flags.
- o_tx_data  out  8  current frame byte.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  sink accepts the byte.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse after the final byte is accepted.

## Operation
- States and transitions:
  - IDLE: go to SEND when i_dump_req=1.
  - SEND: bytes 0..24. Go to CKSUM after byte 24 is accepted.
  - CKSUM: byte 25. Go to IDLE after it is accepted.
- Snapshot: on the edge that leaves IDLE, all inputs are latched into internal words. Input changes after that edge do not affect the frame.
- Packed control words:
  - C0 = {rd, rt, rs, ALU_opcode, AGU_opcode, ALU_dst, flg_mem_size, flg_ALU_src_A, flg_ALU_src_B, AGU_dst, flg_equal, flg_unsign}, 32 bits, MSB first.
  - C1 = {addr_offset, flg_branch, flg_jump, flg_reg_wr_en, flg_mem_wr_en, flg_wb_src, 1'b0}, 32 bits.
- Frame byte order, each word big-endian:
  - HEADER
  - pc[31:24..7:0]
  - ALU_src_A
  - ALU_src_B
  - AGU_src_addr
  - C0
  - C1
  - CHK
- CHK is the XOR of bytes 0..24.
- Byte index is a 5-bit counter, 0..25. It advances only on a transfer (o_tx_valid & i_tx_ready at a posedge). It clears on return to IDLE.
- The running XOR accumulator updates on each transfer and clears on entering SEND.
- i_dump_req is ignored while o_busy=1. It is not queued.

## Timing
- Reset values: o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0. State IDLE, byte index 0, accumulator 0.
- Reset mid-frame aborts immediately: o_tx_valid=0 next cycle, no o_done. The next frame starts from HEADER.
- Start latency: i_dump_req high at edge N gives o_busy=1, o_tx_valid=1 and o_tx_data=HEADER in cycle N+1.
- Handshake:
  - o_tx_valid stays high continuously from the first byte through CHK.
  - o_tx_data is stable while o_tx_valid=1 and i_tx_ready=0.
  - On a transfer, the next byte is presented in the following cycle with no bubble.
  - i_tx_ready while o_tx_valid=0 has no effect.
- Full throughput (i_tx_ready=1 always): 26 bytes are transferred at edges N+1..N+26.
- End of frame: o_done=1, o_busy=0, o_tx_valid=0 in cycle N+27 only.
- A request sampled at edge N+27, in the o_done cycle, is accepted. The minimum request-to-request spacing is 27 cycles.
- Backpressure of k stall cycles delays o_done by exactly k cycles.

## Test plan
- All inputs 0, request, ready=1 -> bytes A5, 24×00, CHK A5. o_done in cycle N+27.
- pc=0x00400010, rd=5'h1F, others 0 -> bytes 1..4 = 00 40 00 10. C0 bytes = F8 00 00 00. CHK = A5^40^10^F8 = 0x0D.
- Same frame, i_tx_ready toggled 1,0,0,1 repeating -> identical byte sequence. o_tx_data is held during every stall. o_done is delayed by the stall count.
- Change all inputs and pulse i_dump_req at byte 10 -> frame content unchanged. No second frame follows.
- Assert i_rst at byte 12 -> o_tx_valid=0 and o_busy=0 next cycle, no o_done. A following request emits a full frame starting with A5.
- i_dump_req held high, ready=1 -> back-to-back frames, each starting in the cycle after the previous o_done.

Source files
------------

// File: rtl/id_ex_dump_tx.sv
// ---------------------------------------------------------------------------
// id_ex_dump_tx
//
// Debug-side reader of the ID/EX pipeline latch. A dump request freezes a
// copy of every ID/EX output field in a single cycle. The copy is then sent
// as a fixed 26-byte frame over a byte-wide valid/ready stream that feeds the
// debug UART transmitter. The block only observes the pipeline; it never
// stalls it or alters it.
//
// Frame layout (each word big-endian):
//   byte  0       HEADER
//   bytes 1..4    pc
//   bytes 5..8    ALU_src_A
//   bytes 9..12   ALU_src_B
//   bytes 13..16  AGU_src_addr
//   bytes 17..20  C0 = {rd, rt, rs, ALU_opcode, AGU_opcode, ALU_dst,
//                       flg_mem_size, flg_ALU_src_A, flg_ALU_src_B, AGU_dst,
//                       flg_equal, flg_unsign}
//   bytes 21..24  C1 = {addr_offset, flg_branch, flg_jump, flg_reg_wr_en,
//                       flg_mem_wr_en, flg_wb_src, 1'b0}
//   byte  25      XOR of bytes 0..24
//
// Parameters:
//   NBITS   datapath width; the frame layout assumes 32
//   HEADER  first byte of every frame
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_dump_req            start a dump (sampled only while idle)
//   i_pc .. i_flg_*       ID/EX latch outputs that are snapshotted
//   o_tx_data/o_tx_valid  byte stream towards the UART
//   i_tx_ready            sink accepts the current byte
//   o_busy                frame in progress
//   o_done                one-cycle pulse after the checksum byte is taken
// ---------------------------------------------------------------------------
module id_ex_dump_tx #(
    parameter int          NBITS  = 32,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dump_req,

    input  logic [NBITS-1:0] i_pc,
    input  logic [NBITS-1:0] i_ALU_src_A,
    input  logic [NBITS-1:0] i_ALU_src_B,
    input  logic [NBITS-1:0] i_AGU_src_addr,
    input  logic [4:0]       i_rd,
    input  logic [4:0]       i_rt,
    input  logic [4:0]       i_rs,
    input  logic [25:0]      i_addr_offset,
    input  logic [3:0]       i_ALU_opcode,
    input  logic [2:0]       i_AGU_opcode,
    input  logic [1:0]       i_ALU_dst,
    input  logic [1:0]       i_flg_mem_size,
    input  logic [1:0]       i_flg_ALU_src_A,
    input  logic             i_flg_equal,
    input  logic             i_flg_unsign,
    input  logic             i_AGU_dst,
    input  logic             i_flg_branch,
    input  logic             i_flg_jump,
    input  logic             i_flg_reg_wr_en,
    input  logic             i_flg_mem_wr_en,
    input  logic             i_flg_wb_src,
    input  logic             i_flg_ALU_src_B,

    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_busy,
    output logic             o_done
);

    // Index of the last payload byte; the checksum byte follows it.
    localparam logic [4:0] LAST_PAYLOAD_IDX = 5'd24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CKSUM = 2'd2
    } state_t;

    state_t           state_q;

    // Snapshot of the ID/EX latch, frozen for the whole frame.
    logic [NBITS-1:0] pc_q;
    logic [NBITS-1:0] aluSrcA_q;
    logic [NBITS-1:0] aluSrcB_q;
    logic [NBITS-1:0] aguSrcAddr_q;
    logic [31:0]      ctrl0_q;
    logic [31:0]      ctrl1_q;

    // Stream bookkeeping.
    logic [4:0]       byteIdx_q;
    logic [7:0]       acc_q;
    logic [7:0]       txData_q;
    logic             txValid_q;
    logic             busy_q;
    logic             done_q;

    // Combinational helpers.
    logic [31:0]      ctrl0_d;
    logic [31:0]      ctrl1_d;
    logic             transfer;
    logic [4:0]       byteIdx_d;
    logic [7:0]       nextByte_d;
    logic [7:0]       accNext_d;

    // Control fields are packed into two 32-bit words at capture time.
    // The payload mux then treats all six words the same way.
    assign ctrl0_d = {i_rd, i_rt, i_rs, i_ALU_opcode, i_AGU_opcode, i_ALU_dst,
                      i_flg_mem_size, i_flg_ALU_src_A, i_flg_ALU_src_B,
                      i_AGU_dst, i_flg_equal, i_flg_unsign};

    assign ctrl1_d = {i_addr_offset, i_flg_branch, i_flg_jump,
                      i_flg_reg_wr_en, i_flg_mem_wr_en, i_flg_wb_src, 1'b0};

    assign transfer  = txValid_q & i_tx_ready;
    assign byteIdx_d = byteIdx_q + 5'd1;
    assign accNext_d = acc_q ^ txData_q;

    // Selects the payload byte that goes out after the current one.
    // The byte is taken from the frozen snapshot, so a transfer on one edge
    // presents the next byte in the following cycle with no bubble.
    always_comb begin
        nextByte_d = 8'h00;
        case (byteIdx_d)
            5'd1:    nextByte_d = pc_q[31:24];
            5'd2:    nextByte_d = pc_q[23:16];
            5'd3:    nextByte_d = pc_q[15:8];
            5'd4:    nextByte_d = pc_q[7:0];
            5'd5:    nextByte_d = aluSrcA_q[31:24];
            5'd6:    nextByte_d = aluSrcA_q[23:16];
            5'd7:    nextByte_d = aluSrcA_q[15:8];
            5'd8:    nextByte_d = aluSrcA_q[7:0];
            5'd9:    nextByte_d = aluSrcB_q[31:24];
            5'd10:   nextByte_d = aluSrcB_q[23:16];
            5'd11:   nextByte_d = aluSrcB_q[15:8];
            5'd12:   nextByte_d = aluSrcB_q[7:0];
            5'd13:   nextByte_d = aguSrcAddr_q[31:24];
            5'd14:   nextByte_d = aguSrcAddr_q[23:16];
            5'd15:   nextByte_d = aguSrcAddr_q[15:8];
            5'd16:   nextByte_d = aguSrcAddr_q[7:0];
            5'd17:   nextByte_d = ctrl0_q[31:24];
            5'd18:   nextByte_d = ctrl0_q[23:16];
            5'd19:   nextByte_d = ctrl0_q[15:8];
            5'd20:   nextByte_d = ctrl0_q[7:0];
            5'd21:   nextByte_d = ctrl1_q[31:24];
            5'd22:   nextByte_d = ctrl1_q[23:16];
            5'd23:   nextByte_d = ctrl1_q[15:8];
            5'd24:   nextByte_d = ctrl1_q[7:0];
            default: nextByte_d = 8'h00;
        endcase
    end

    // Frame FSM with registered stream outputs.
    // IDLE captures the snapshot and presents HEADER in the same edge.
    // In SEND the state advances only on accepted bytes. The checksum is
    // formed from the running XOR plus byte 24 as it is accepted. o_done is
    // a pulse that falls back to zero unless the final byte is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            aluSrcA_q    <= '0;
            aluSrcB_q    <= '0;
            aguSrcAddr_q <= '0;
            ctrl0_q      <= '0;
            ctrl1_q      <= '0;
            byteIdx_q    <= '0;
            acc_q        <= '0;
            txData_q     <= '0;
            txValid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_dump_req) begin
                        pc_q         <= i_pc;
                        aluSrcA_q    <= i_ALU_src_A;
                        aluSrcB_q    <= i_ALU_src_B;
                        aguSrcAddr_q <= i_AGU_src_addr;
                        ctrl0_q      <= ctrl0_d;
                        ctrl1_q      <= ctrl1_d;
                        byteIdx_q    <= '0;
                        acc_q        <= '0;
                        txData_q     <= HEADER;
                        txValid_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= SEND;
                    end
                end

                SEND: begin
                    if (transfer) begin
                        acc_q     <= accNext_d;
                        byteIdx_q <= byteIdx_d;
                        if (byteIdx_q == LAST_PAYLOAD_IDX) begin
                            txData_q <= accNext_d;
                            state_q  <= CKSUM;
                        end else begin
                            txData_q <= nextByte_d;
                        end
                    end
                end

                CKSUM: begin
                    if (transfer) begin
                        byteIdx_q <= '0;
                        txData_q  <= '0;
                        txValid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end
                end

                default: begin
                    byteIdx_q <= '0;
                    txValid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_tx_data  = txData_q;
    assign o_tx_valid = txValid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_id_ex_dump_tx.sv
// ---------------------------------------------------------------------------
// tb_id_ex_dump_tx
//
// Self-checking bench for id_ex_dump_tx. Each frame's expected bytes are
// pushed to a queue when the request is driven. A negedge monitor compares
// every valid byte against the queue head and pops the head on a handshake.
// Table vectors carry hand-computed checksums. Further sequences cover:
//   - input changes in the middle of a frame
//   - reset in the middle of a frame
//   - back-to-back frames
// ---------------------------------------------------------------------------
module tb_id_ex_dump_tx;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] srcA;
        logic [31:0] srcB;
        logic [31:0] agu;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [4:0]  rs;
        logic [25:0] off;
        logic [3:0]  aluOp;
        logic [2:0]  aguOp;
        logic [1:0]  aluDst;
        logic [1:0]  memSize;
        logic [1:0]  srcAFlg;
        logic        eq;
        logic        uns;
        logic        aguDst;
        logic        br;
        logic        jmp;
        logic        regWr;
        logic        memWr;
        logic        wbSrc;
        logic        srcBFlg;
        int          readyMode;
        logic [7:0]  expChk;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_dump_req;
    logic [31:0] i_pc, i_ALU_src_A, i_ALU_src_B, i_AGU_src_addr;
    logic [4:0]  i_rd, i_rt, i_rs;
    logic [25:0] i_addr_offset;
    logic [3:0]  i_ALU_opcode;
    logic [2:0]  i_AGU_opcode;
    logic [1:0]  i_ALU_dst, i_flg_mem_size, i_flg_ALU_src_A;
    logic        i_flg_equal, i_flg_unsign, i_AGU_dst, i_flg_branch, i_flg_jump;
    logic        i_flg_reg_wr_en, i_flg_mem_wr_en, i_flg_wb_src, i_flg_ALU_src_B;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;

    int          nCompared   = 0;
    int          nMismatched = 0;
    int          cyc         = 0;
    logic [7:0]  expQ[$];
    vec_t        vecs[4];

    id_ex_dump_tx #(.NBITS(32), .HEADER(8'hA5)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_dump_req     (i_dump_req),
        .i_pc           (i_pc),
        .i_ALU_src_A    (i_ALU_src_A),
        .i_ALU_src_B    (i_ALU_src_B),
        .i_AGU_src_addr (i_AGU_src_addr),
        .i_rd           (i_rd),
        .i_rt           (i_rt),
        .i_rs           (i_rs),
        .i_addr_offset  (i_addr_offset),
        .i_ALU_opcode   (i_ALU_opcode),
        .i_AGU_opcode   (i_AGU_opcode),
        .i_ALU_dst      (i_ALU_dst),
        .i_flg_mem_size (i_flg_mem_size),
        .i_flg_ALU_src_A(i_flg_ALU_src_A),
        .i_flg_equal    (i_flg_equal),
        .i_flg_unsign   (i_flg_unsign),
        .i_AGU_dst      (i_AGU_dst),
        .i_flg_branch   (i_flg_branch),
        .i_flg_jump     (i_flg_jump),
        .i_flg_reg_wr_en(i_flg_reg_wr_en),
        .i_flg_mem_wr_en(i_flg_mem_wr_en),
        .i_flg_wb_src   (i_flg_wb_src),
        .i_flg_ALU_src_B(i_flg_ALU_src_B),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    // Free-running clock and edge counter.
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every presented byte must match the queue head.
    // This also covers the hold-during-stall rule. A valid byte with an
    // empty queue is an unexpected frame.
    always @(negedge i_clk) begin
        if (!i_rst && o_tx_valid) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected byte: got 0x%0h, expected no valid byte (cycle %0d)", o_tx_data, cyc);
            end else begin
                checkOutput("tx_data", {24'h0, o_tx_data}, {24'h0, expQ[0]});
                if (i_tx_ready) void'(expQ.pop_front());
            end
        end
    end

    function automatic vec_t zeroVec();
        vec_t v;
        v = '{default: 0};
        return v;
    endfunction

    // Mode 0: always ready. Mode 1: ready follows 1,0,0,1 from the first frame cycle.
    function automatic logic readyAt(input int mode, input int c);
        if (mode == 0) return 1'b1;
        case ((c - 1) % 4)
            0:       return 1'b1;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Cycle offset (from the request edge) at which o_done should be seen.
    function automatic int expDoneOffset(input int mode);
        int ones = 0;
        int c    = 0;
        while (ones < 26) begin
            c++;
            if (readyAt(mode, c)) ones++;
        end
        return c + 1;
    endfunction

    task automatic pushFrame(input vec_t v);
        logic [31:0] w[6];
        w[0] = v.pc;
        w[1] = v.srcA;
        w[2] = v.srcB;
        w[3] = v.agu;
        w[4] = {v.rd, v.rt, v.rs, v.aluOp, v.aguOp, v.aluDst, v.memSize,
                v.srcAFlg, v.srcBFlg, v.aguDst, v.eq, v.uns};
        w[5] = {v.off, v.br, v.jmp, v.regWr, v.memWr, v.wbSrc, 1'b0};
        expQ.push_back(8'hA5);
        for (int i = 0; i < 6; i++)
            for (int b = 3; b >= 0; b--)
                expQ.push_back(w[i][8*b +: 8]);
        expQ.push_back(v.expChk);
    endtask

    task automatic driveFields(input vec_t v);
        i_pc            = v.pc;
        i_ALU_src_A     = v.srcA;
        i_ALU_src_B     = v.srcB;
        i_AGU_src_addr  = v.agu;
        i_rd            = v.rd;
        i_rt            = v.rt;
        i_rs            = v.rs;
        i_addr_offset   = v.off;
        i_ALU_opcode    = v.aluOp;
        i_AGU_opcode    = v.aguOp;
        i_ALU_dst       = v.aluDst;
        i_flg_mem_size  = v.memSize;
        i_flg_ALU_src_A = v.srcAFlg;
        i_flg_equal     = v.eq;
        i_flg_unsign    = v.uns;
        i_AGU_dst       = v.aguDst;
        i_flg_branch    = v.br;
        i_flg_jump      = v.jmp;
        i_flg_reg_wr_en = v.regWr;
        i_flg_mem_wr_en = v.memWr;
        i_flg_wb_src    = v.wbSrc;
        i_flg_ALU_src_B = v.srcBFlg;
    endtask

    task automatic randomFields();
        vec_t r;
        r = zeroVec();
        r.pc   = $urandom;  r.srcA = $urandom;  r.srcB = $urandom;  r.agu = $urandom;
        r.rd   = 5'h1B;     r.rt   = 5'h0E;     r.rs   = 5'h13;     r.off = 26'h2AB_CDEF;
        r.aluOp = 4'hC;     r.aguOp = 3'h5;     r.aluDst = 2'h3;     r.memSize = 2'h2;
        r.srcAFlg = 2'h1;   r.eq = 1;  r.uns = 1;  r.aguDst = 1;  r.br = 1;  r.jmp = 1;
        r.regWr = 1;  r.memWr = 1;  r.wbSrc = 1;  r.srcBFlg = 1;
        driveFields(r);
    endtask

    // Runs one frame: requests it, drives ready per mode and checks o_done
    // timing. If disturbAt is nonzero, the inputs change and a new request
    // is pulsed while byte disturbAt is on the bus.
    task automatic applyStimulus(input vec_t v, input int disturbAt);
        bit doneSeen = 0;
        pushFrame(v);
        @(negedge i_clk);
        driveFields(v);
        i_dump_req = 1'b1;
        @(posedge i_clk);
        #1;
        i_dump_req = 1'b0;
        for (int c = 1; c <= 200 && !doneSeen; c++) begin
            i_tx_ready = readyAt(v.readyMode, c);
            if (disturbAt != 0 && c == disturbAt + 1) begin
                randomFields();
                i_dump_req = 1'b1;
            end
            if (disturbAt != 0 && c == disturbAt + 2) i_dump_req = 1'b0;
            @(negedge i_clk);
            if (c == 1) checkOutput("busy/valid at start", {30'h0, o_busy, o_tx_valid}, 32'h3);
            if (o_done) begin
                doneSeen = 1;
                checkOutput("done cycle offset", c, expDoneOffset(v.readyMode));
                checkOutput("busy/valid at done", {30'h0, o_busy, o_tx_valid}, 32'h0);
            end
            @(posedge i_clk);
            #1;
        end
        if (!doneSeen) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL done timeout: got no o_done, expected one within 200 cycles");
        end
        checkOutput("frame bytes left", expQ.size(), 0);
        @(negedge i_clk);
        checkOutput("idle after done", {29'h0, o_done, o_tx_valid, o_busy}, 32'h0);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_dump_req = 1'b0;
        i_tx_ready = 1'b0;
        driveFields(zeroVec());

        // Vector table: all zeros, known pc/rd frame, same frame with
        // stalls, and a frame with flag bits in C0/C1.
        vecs[0] = zeroVec();
        vecs[0].expChk = 8'hA5;

        vecs[1] = zeroVec();
        vecs[1].pc = 32'h0040_0010;
        vecs[1].rd = 5'h1F;
        vecs[1].expChk = 8'h0D;

        vecs[2] = vecs[1];
        vecs[2].readyMode = 1;

        vecs[3] = zeroVec();
        vecs[3].srcA = 32'h0102_0304;
        vecs[3].jmp = 1'b1;
        vecs[3].uns = 1'b1;
        vecs[3].expChk = 8'hB0;

        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_tx_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("reset tx_data", {24'h0, o_tx_data}, 32'h0);
        checkOutput("reset tx_valid", {31'h0, o_tx_valid}, 32'h0);
        checkOutput("reset busy", {31'h0, o_busy}, 32'h0);
        checkOutput("reset done", {31'h0, o_done}, 32'h0);

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i], 0);
        end

        $display("[TB] input change and request during byte 10");
        applyStimulus(vecs[1], 10);

        // Reset while byte 12 is on the bus, then a clean frame.
        $display("[TB] reset mid-frame");
        begin
            int doneCount = 0;
            pushFrame(vecs[1]);
            @(negedge i_clk);
            driveFields(vecs[1]);
            i_dump_req = 1'b1;
            i_tx_ready = 1'b1;
            @(posedge i_clk);
            #1;
            i_dump_req = 1'b0;
            repeat (12) begin
                @(posedge i_clk);
                #1;
            end
            i_rst = 1'b1;
            expQ.delete();
            @(posedge i_clk);
            #1;
            i_rst = 1'b0;
            @(negedge i_clk);
            checkOutput("valid/busy after abort", {30'h0, o_tx_valid, o_busy}, 32'h0);
            checkOutput("tx_data after abort", {24'h0, o_tx_data}, 32'h0);
            repeat (30) begin
                @(negedge i_clk);
                if (o_done) doneCount++;
            end
            checkOutput("done after abort", doneCount, 0);
        end
        applyStimulus(vecs[1], 0);

        // Request held high: the second frame starts in the cycle after
        // the first o_done.
        $display("[TB] back-to-back frames");
        begin
            int doneAt[$];
            pushFrame(vecs[1]);
            pushFrame(vecs[1]);
            @(negedge i_clk);
            driveFields(vecs[1]);
            i_dump_req = 1'b1;
            i_tx_ready = 1'b1;
            @(posedge i_clk);
            #1;
            for (int c = 1; c <= 120 && doneAt.size() < 2; c++) begin
                if (c == 28) i_dump_req = 1'b0;
                @(negedge i_clk);
                if (c == 28) checkOutput("second frame start", {30'h0, o_busy, o_tx_valid}, 32'h3);
                if (o_done) doneAt.push_back(c);
                @(posedge i_clk);
                #1;
            end
            i_dump_req = 1'b0;
            if (doneAt.size() < 2) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL back-to-back timeout: got %0d done pulses, expected 2", doneAt.size());
            end else begin
                checkOutput("first done offset", doneAt[0], 27);
                checkOutput("second done offset", doneAt[1], 54);
            end
            checkOutput("b2b bytes left", expQ.size(), 0);
            @(negedge i_clk);
            checkOutput("idle after b2b", {29'h0, o_done, o_tx_valid, o_busy}, 32'h0);
        end

        repeat (3) @(posedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
